stepmotor_phase_decoder: RTL and testbench
==========================================

// Module: stepmotor_phase_decoder
// PURPOSE
// - Reader for the 4-bit phase bus driven to the step-motor driver: samples phases, decodes
//   single steps and their direction, and keeps a signed step position.
// - Flags illegal or skipped patterns, detects stalls, and signals arrival at an armed target.
// - Sits beside the motor wrapper in the game top. Game logic uses its position/target
//   outputs to close the loop on token moves.
// PARAMETERS
// - POS_W        16        width of signed position counter
// - STALL_CYCLES 1_000_000 cycles without a step before moving drops (>=2)
// PORTS
// - clk         in   1      system clock
// - rst_n       in   1      async active-low reset
// - phases      in   4      phase bus as driven to motor driver (asynchronous to decode)
// - clear       in   1      sync: zero position, clear fault, disarm target
// - tgt_valid   in   1      target offer
// - tgt_ready   out  1      high when no target armed
// - tgt_pos     in   POS_W  signed target position
// - position    out  POS_W  signed step count (fwd +1, rev -1)
// - step_pulse  out  1      1-cycle pulse per decoded step
// - dir         out  1      direction of last step (1=fwd)
// - moving      out  1      a step occurred within STALL_CYCLES
// - at_target   out  1      1-cycle pulse when position reaches armed target
// - fault       out  1      sticky: illegal or skipped phase pattern
// BEHAVIOUR
// - Reset values: position=0, dir=0, step_pulse=0, moving=0, at_target=0, fault=0,
//   tgt_ready=1. Phase synchroniser and prev index are cleared; FSM=IDLE.
// - Input sync: 2-flop synchroniser on phases. Decode compares the synced value to the prev index.
// - Legal patterns: 4'b0001=idx0, 0010=idx1, 0100=idx2, 1000=idx3; 4'b0000=stopped.
// - Any other pattern is illegal.
// - Latency: phases edge -> step_pulse/position/dir update 3 clk later.
// - FSM IDLE: no legal non-zero pattern seen yet.
//   - First legal pattern loads prev idx and moves to TRACK, with no step.
//   - Illegal pattern -> FAULT.
// - FSM TRACK:
//   - idx==prev+1 mod 4 -> pos+1, dir=1, step_pulse.
//   - idx==prev-1 mod 4 -> pos-1, dir=0, step_pulse.
//   - idx==prev -> no-op.
//   - 0000 -> no-op; prev is held.
//   - idx==prev+2 mod 4 (skip) or illegal -> FAULT, fault=1.
//   - prev updates on every legal non-zero pattern.
// - FSM FAULT: no decoding and position frozen. Only clear exits, to IDLE. rst_n also exits.
// - Position wraps two's complement at POS_W (0x7FFF+1 -> 0x8000).
// - Stall counter resets on step_pulse, saturating at STALL_CYCLES-1.
//   - moving=1 on step_pulse; 0 when the counter saturates.
// - Target handshake: accept on tgt_valid&tgt_ready. Latch tgt_pos and arm; tgt_ready=0.
//   - Each cycle while armed, if position==target: at_target pulse next cycle, then disarm.
//   - Accept while position already equals target -> at_target 2 cycles after accept.
// - clear has priority over a simultaneous step: position=0, step dropped, fault=0, disarm.
//   - FSM -> IDLE, so the next legal pattern re-seeds prev.
// - rst_n mid-step: all state returns to reset values immediately; no pulse is emitted.
// STRUCTURE
// - Shared package stepmotor_pkg: phase pattern constants (PH_IDX0..3, PH_STOP).
// - Package also holds the typedef enum {IDLE, TRACK, FAULT} dec_state_t and the
//   function phase_to_idx returning {legal, idx[1:0]}.
// - One sub-module: phase_sync, a 2-flop 4-bit synchroniser with async active-low reset.
// - FSM, position, stall counter and target logic stay in this module.
// TESTING
// - Fwd sequence 0001,0010,0100,1000,0001, each held 10 clk:
//   - 4 step_pulse, position=4, dir=1, pulse 3 clk after each edge.
// - Reverse 0001,1000,0100: position=-2 (0xFFFE), dir=0.
// - Insert 0000 between 0010 and 0100: no step on 0000, step on 0100, fault=0.
// - Skip 0001->0100, then 0011: fault=1 and position frozen. clear -> fault=0, position=0, IDLE.
// - tgt_pos=3 accepted at position 0:
//   - tgt_ready=0; after 3 fwd steps at_target pulses once, then tgt_ready=1.
// - STALL_CYCLES=8: one step then hold -> moving=1, drops to 0 after 8 clk.
// - Also check position wrap 0x7FFF->0x8000 with POS_W=16.

Source files
------------

// File: rtl/stepmotor_pkg.sv
// Phase-bus encodings, decoder states and the pattern-to-index helper shared by the decoder.
package stepmotor_pkg;

  localparam logic [3:0] PH_STOP = 4'b0000;
  localparam logic [3:0] PH_IDX0 = 4'b0001;
  localparam logic [3:0] PH_IDX1 = 4'b0010;
  localparam logic [3:0] PH_IDX2 = 4'b0100;
  localparam logic [3:0] PH_IDX3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } dec_state_t;

  // {legal, idx}; PH_STOP and every multi-hot pattern report legal=0.
  function automatic logic [2:0] phase_to_idx(input logic [3:0] ph);
    logic [2:0] r;
    r = 3'b000;
    case (ph)
      PH_IDX0: r = {1'b1, 2'd0};
      PH_IDX1: r = {1'b1, 2'd1};
      PH_IDX2: r = {1'b1, 2'd2};
      PH_IDX3: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stepmotor_phase_decoder_phase_sync.sv
// Two-flop synchroniser for the 4-bit phase bus; 2 clk latency, no backpressure.
module phase_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/stepmotor_phase_decoder.sv
// Decodes motor phase steps into a signed position with fault, stall and target tracking.
// Phase edge to step_pulse/position is 3 clk; target offers are held off (tgt_ready=0) while armed.
module stepmotor_phase_decoder
  import stepmotor_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       phases,
  input  logic             clear,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [POS_W-1:0] tgt_pos,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             dir,
  output logic             moving,
  output logic             at_target,
  output logic             fault
);

  localparam int                CNT_W   = $clog2(STALL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STALL_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_ONE = POS_W'(1);

  logic [3:0]       ph_sync;
  logic             ph_legal;
  logic [1:0]       ph_idx;
  logic             ph_stop;
  logic [1:0]       delta;

  dec_state_t       state_q,  state_d;
  logic [1:0]       prev_q,   prev_d;
  logic [POS_W-1:0] pos_q,    pos_d;
  logic             dir_q,    dir_d;
  logic             step_q,   step_d;
  logic             moving_q, moving_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             armed_q,  armed_d;
  logic [POS_W-1:0] tgt_q,    tgt_d;
  logic             at_tgt_q, at_tgt_d;
  logic             fault_q,  fault_d;

  phase_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (phases),
    .q     (ph_sync)
  );

  assign {ph_legal, ph_idx} = phase_to_idx(ph_sync);
  assign ph_stop            = (ph_sync == PH_STOP);
  assign delta              = ph_idx - prev_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    moving_d = moving_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    tgt_d    = tgt_q;
    at_tgt_d = 1'b0;
    fault_d  = fault_q;

    case (state_q)
      IDLE: begin
        if (ph_legal) begin
          prev_d  = ph_idx;
          state_d = TRACK;
        end else if (!ph_stop) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      TRACK: begin
        if (ph_legal) begin
          // delta of 2 means a phase was skipped and direction is ambiguous
          case (delta)
            2'd1: begin
              pos_d  = pos_q + POS_ONE;
              dir_d  = 1'b1;
              step_d = 1'b1;
              prev_d = ph_idx;
            end
            2'd3: begin
              pos_d  = pos_q - POS_ONE;
              dir_d  = 1'b0;
              step_d = 1'b1;
              prev_d = ph_idx;
            end
            2'd0:    prev_d = ph_idx;
            default: begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          endcase
        end else if (!ph_stop) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (armed_q) begin
      if (pos_q == tgt_q) begin
        at_tgt_d = 1'b1;
        armed_d  = 1'b0;
      end
    end else if (tgt_valid) begin
      tgt_d   = tgt_pos;
      armed_d = 1'b1;
    end

    // clear wins over any step or target event decoded in the same cycle
    if (clear) begin
      state_d  = IDLE;
      pos_d    = '0;
      step_d   = 1'b0;
      dir_d    = dir_q;
      fault_d  = 1'b0;
      armed_d  = 1'b0;
      at_tgt_d = 1'b0;
    end

    if (step_d) begin
      cnt_d    = '0;
      moving_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      moving_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      moving_q <= 1'b0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      tgt_q    <= '0;
      at_tgt_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      moving_q <= moving_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      tgt_q    <= tgt_d;
      at_tgt_q <= at_tgt_d;
      fault_q  <= fault_d;
    end
  end

  assign tgt_ready  = ~armed_q;
  assign position   = pos_q;
  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign at_target  = at_tgt_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_stepmotor_phase_decoder.sv
// Scoreboard bench: stimulus pushes predicted step/target events, a negedge monitor pops and compares.
module tb_stepmotor_phase_decoder;

  localparam int POS_W = 16;
  localparam int STALL = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       phases;
  logic             clear;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [POS_W-1:0] tgt_pos;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic             moving;
  logic             at_target;
  logic             fault;

  always #5 clk = ~clk;

  stepmotor_phase_decoder #(.POS_W(POS_W), .STALL_CYCLES(STALL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phases     (phases),
    .clear      (clear),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_pos    (tgt_pos),
    .position   (position),
    .step_pulse (step_pulse),
    .dir        (dir),
    .moving     (moving),
    .at_target  (at_target),
    .fault      (fault)
  );

  typedef struct {
    int         cyc;
    logic [15:0] pos;
    logic        dir;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   at_q[$];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // reference model state: position as an unbounded integer, phase index as 0..3
  int m_pos, m_prev, m_tgt;
  bit m_dir, m_seed, m_fault, m_armed;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_eval(input logic [3:0] ph);
    int idx;
    int d;
    exp_t e;
    idx = -1;
    for (int i = 0; i < 4; i++) if (ph == (4'b0001 << i)) idx = i;
    if (m_fault || ph == 4'b0000) return;
    if (idx < 0) begin
      m_fault = 1'b1;
      return;
    end
    if (!m_seed) begin
      m_seed = 1'b1;
      m_prev = idx;
      return;
    end
    d = (idx - m_prev + 4) % 4;
    if (d == 2) begin
      m_fault = 1'b1;
      return;
    end
    m_prev = idx;
    if (d == 0) return;
    if (d == 1) begin
      m_pos++;
      m_dir = 1'b1;
    end else begin
      m_pos--;
      m_dir = 1'b0;
    end
    e.cyc = cyc + 3;
    e.pos = 16'(m_pos);
    e.dir = m_dir;
    exp_q.push_back(e);
    pulse_q.push_back(cyc + 3);
    if (m_armed && 16'(m_pos) == 16'(m_tgt)) begin
      at_q.push_back(cyc + 4);
      m_armed = 1'b0;
    end
  endtask

  task automatic apply(input logic [3:0] ph, input int hold);
    phases = ph;
    model_eval(ph);
    repeat (hold) tick();
  endtask

  task automatic do_clear();
    apply(4'b0000, 6);
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    m_pos   = 0;
    m_fault = 1'b0;
    m_seed  = 1'b0;
    m_armed = 1'b0;
    chk("clear_pos", position, 0);
    chk("clear_fault", fault, 0);
  endtask

  task automatic offer(input int t);
    chk("tgt_ready_idle", tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt_pos   = 16'(t);
    tick();
    tgt_valid = 1'b0;
    chk("tgt_ready_armed", tgt_ready, 0);
    m_armed = 1'b1;
    m_tgt   = t;
    if (16'(m_pos) == 16'(t)) begin
      at_q.push_back(cyc + 1);
      m_armed = 1'b0;
    end
  endtask

  // monitor
  exp_t e_mon;
  int   last_pulse;
  bit   have_last;
  int   at_c;

  always @(negedge clk) begin
    if (!mon_en) begin
      have_last = 1'b0;
    end else begin
      while (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
        last_pulse = pulse_q.pop_front();
        have_last  = 1'b1;
      end
      chk("moving", moving, 32'(have_last && (cyc - last_pulse) < STALL));
      if (step_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("step_unexpected", step_pulse, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("step_cycle", cyc, e_mon.cyc);
          chk("step_pos", position, e_mon.pos);
          chk("step_dir", dir, e_mon.dir);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("step_missing", step_pulse, 1);
        e_mon = exp_q.pop_front();
      end
      if (at_target === 1'b1) begin
        if (at_q.size() == 0) begin
          chk("at_target_unexpected", at_target, 0);
        end else begin
          at_c = at_q.pop_front();
          chk("at_target_cycle", cyc, at_c);
        end
      end else if (at_q.size() > 0 && at_q[0] <= cyc) begin
        chk("at_target_missing", at_target, 1);
        at_c = at_q.pop_front();
      end
    end
  end

  int         cur;
  int         r;
  logic [3:0] ph;

  initial begin
    rst_n = 1'b0;
    phases = 4'b0000;
    clear = 1'b0;
    tgt_valid = 1'b0;
    tgt_pos = '0;
    {m_pos, m_prev, m_tgt} = '0;
    {m_dir, m_seed, m_fault, m_armed} = '0;
    repeat (3) tick();
    chk("rst_position", position, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_moving", moving, 0);
    chk("rst_at_target", at_target, 0);
    chk("rst_fault", fault, 0);
    chk("rst_tgt_ready", tgt_ready, 1);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // forward full revolution
    apply(4'b0001, 10); apply(4'b0010, 10); apply(4'b0100, 10);
    apply(4'b1000, 10); apply(4'b0001, 10);
    chk("fwd_pos", position, 4);
    chk("fwd_dir", dir, 1);

    // reverse from zero
    do_clear();
    apply(4'b0001, 10); apply(4'b1000, 10); apply(4'b0100, 10);
    chk("rev_pos", position, 16'hFFFE);
    chk("rev_dir", dir, 0);

    // stop pattern in the middle of a move
    do_clear();
    apply(4'b0001, 10); apply(4'b0010, 10); apply(4'b0000, 10); apply(4'b0100, 10);
    chk("stop_pos", position, 2);
    chk("stop_fault", fault, 0);

    // random walk of legal moves, holds and stops
    cur = 2;
    repeat (80) begin
      r = $urandom_range(0, 3);
      if (r == 0) cur = (cur + 1) % 4;
      if (r == 1) cur = (cur + 3) % 4;
      if (r == 3) apply(4'b0000, $urandom_range(1, 12));
      ph = 4'(4'b0001 << cur);
      apply(ph, $urandom_range(1, 12));
    end
    repeat (10) tick();
    chk("rand_pos", position, 16'(m_pos));
    chk("rand_fault", fault, 0);

    // skip then illegal: fault, frozen position, then recovery through clear
    ph = 4'(4'b0001 << ((cur + 2) % 4));
    apply(ph, 10);
    chk("skip_fault", fault, 1);
    chk("skip_pos", position, 16'(m_pos));
    apply(4'b0011, 10);
    ph = 4'(4'b0001 << ((cur + 3) % 4));
    apply(ph, 10);
    chk("frozen_fault", fault, 1);
    chk("frozen_pos", position, 16'(m_pos));
    do_clear();
    apply(4'b0001, 10); apply(4'b0010, 10);
    chk("reseed_pos", position, 1);

    // target 3 from 0, then a target equal to the current position
    do_clear();
    apply(4'b0001, 10);
    offer(3);
    apply(4'b0010, 10); apply(4'b0100, 10); apply(4'b1000, 10);
    chk("tgt_ready_after", tgt_ready, 1);
    offer(3);
    repeat (4) tick();
    chk("tgt_ready_equal", tgt_ready, 1);

    // signed wrap at 0x7FFF -> 0x8000, one step per cycle
    do_clear();
    apply(4'b0001, 2);
    for (int i = 1; i <= 32768; i++) begin
      ph = 4'(4'b0001 << (i % 4));
      apply(ph, 1);
    end
    repeat (6) tick();
    chk("wrap_pos", position, 16'h8000);

    // reset while a step is in the synchroniser: no pulse, state back to reset values
    phases = 4'b0010;
    tick();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_pos", position, 0);
    chk("midrst_fault", fault, 0);
    exp_q.delete();
    pulse_q.delete();
    at_q.delete();
    repeat (4) tick();
    chk("midrst_step", step_pulse, 0);
    rst_n   = 1'b1;
    m_pos   = 0;
    m_seed  = 1'b0;
    m_fault = 1'b0;
    m_armed = 1'b0;
    model_eval(phases);
    tick();
    mon_en = 1'b1;
    apply(4'b0100, 10);
    chk("postrst_pos", position, 1);

    repeat (20) tick();
    chk("steps_drained", exp_q.size(), 0);
    chk("targets_drained", at_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
